// File: rtl/mp_lock_monitor.sv
// mp_lock_monitor: sticky cmp_event latch, per-frame lock verdicts, lock FSM
// and saturating snapshot counters. Optional first-event capture: MP_FIRST_EVENT_EN.
module mp_lock_monitor #(
    parameter int UNLOCK_FRAMES = 4,
    parameter int CW            = 16,
    parameter int WDOG          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sync,
    input  logic [11:0]   cmp_event,
    input  logic [1:0]    lock_sel,
    input  logic [15:0]   lock_count,
    input  logic          slow_snap,
    output logic [11:0]   ev_snap,
    output logic [CW-1:0] clip_frames,
    output logic [CW-1:0] lol_cnt,
    output logic [1:0]    lock_state,
    output logic          locked,
`ifdef MP_FIRST_EVENT_EN
    output logic [11:0]   first_ev,
    output logic [15:0]   first_frame,
`endif
    output logic          sync_err
);

    localparam int WW = $clog2(WDOG + 1);
    localparam logic [WW-1:0] WD_TRIP = WW'(WDOG - 1);
    localparam logic [WW-1:0] WD_MAX  = WW'(WDOG);
    localparam logic [15:0]   UF_LIM  = 16'(UNLOCK_FRAMES);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [15:0]   gcnt, gcnt_n, bcnt, bcnt_n;
    logic [11:0]   sticky, frame_ev, closed;
    logic [WW-1:0] wcnt;
    logic          seen;
    logic [CW-1:0] clip_acc, lol_acc, clip_sum, lol_sum;
    logic [3:0]    lvl_hit;
    logic [15:0]   need, gcnt_inc, bcnt_inc;
    logic          clip_any, judge, bad, wd_trip, clip_inc, lol_inc;

    assign lock_state = state;

    // Close the running frame and grade it at the selected threshold level
    always_comb begin
        closed   = frame_ev | cmp_event;
        lvl_hit  = {|closed[7:6], |closed[5:4], |closed[3:2], |closed[1:0]};
        clip_any = |closed[11:8];
        judge    = sync & seen;
        bad      = lvl_hit[lock_sel] | clip_any;
        clip_inc = judge & clip_any;
        wd_trip  = ~sync & (wcnt >= WD_TRIP);
        need     = (lock_count == 16'd0) ? 16'd1 : lock_count;
        gcnt_inc = (&gcnt) ? gcnt : gcnt + 16'd1;
        bcnt_inc = bcnt + 16'd1;
    end

    // Lock FSM: watchdog overrides, otherwise advance on evaluated closes
    always_comb begin
        state_n = state;
        gcnt_n  = gcnt;
        bcnt_n  = bcnt;
        lol_inc = 1'b0;
        if (wd_trip) begin
            state_n = UNLOCKED;
            gcnt_n  = '0;
            bcnt_n  = '0;
            lol_inc = (state == LOCKED);
        end else if (judge) begin
            unique case (state)
                UNLOCKED: begin
                    if (!bad) begin
                        gcnt_n  = 16'd1;
                        state_n = (need <= 16'd1) ? LOCKED : ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (bad) begin
                        state_n = UNLOCKED;
                        gcnt_n  = '0;
                    end else begin
                        gcnt_n = gcnt_inc;
                        if (gcnt_inc >= need) state_n = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bad) begin
                        if (bcnt_inc >= UF_LIM) begin
                            state_n = UNLOCKED;
                            bcnt_n  = '0;
                            lol_inc = 1'b1;
                        end else begin
                            bcnt_n = bcnt_inc;
                        end
                    end else begin
                        bcnt_n = '0;
                    end
                end
                default: state_n = UNLOCKED;
            endcase
        end
    end

    // Saturating counter values including this cycle's increment
    always_comb begin
        clip_sum = (clip_inc && clip_acc != '1) ? clip_acc + CW'(1) : clip_acc;
        lol_sum  = (lol_inc && lol_acc != '1) ? lol_acc + CW'(1) : lol_acc;
    end

    // Lock state, frame accumulator and watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= UNLOCKED;
            locked   <= 1'b0;
            gcnt     <= '0;
            bcnt     <= '0;
            seen     <= 1'b0;
            frame_ev <= '0;
            wcnt     <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_n;
            locked   <= (state_n == LOCKED);
            gcnt     <= gcnt_n;
            bcnt     <= bcnt_n;
            seen     <= seen | sync;
            frame_ev <= sync ? '0 : closed;
            if (sync) wcnt <= '0;
            else if (wcnt < WD_MAX) wcnt <= wcnt + WW'(1);
            sync_err <= wd_trip | (sync_err & ~slow_snap);
        end
    end

    // Sticky events and counters, handed to the readout on slow_snap
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky      <= '0;
            ev_snap     <= '0;
            clip_acc    <= '0;
            lol_acc     <= '0;
            clip_frames <= '0;
            lol_cnt     <= '0;
        end else if (slow_snap) begin
            sticky      <= '0;
            ev_snap     <= sticky | cmp_event;
            clip_acc    <= '0;
            lol_acc     <= '0;
            clip_frames <= clip_sum;
            lol_cnt     <= lol_sum;
        end else begin
            sticky   <= sticky | cmp_event;
            clip_acc <= clip_sum;
            lol_acc  <= lol_sum;
        end
    end

`ifdef MP_FIRST_EVENT_EN
    logic [15:0] frame_no, sh_frame;
    logic [11:0] sh_ev;
    logic        sh_full, first_hit;

    assign first_hit = ~sh_full & (cmp_event != 12'd0);

    // First nonzero event after each snap, tagged with its frame number
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_no    <= '0;
            sh_frame    <= '0;
            sh_ev       <= '0;
            sh_full     <= 1'b0;
            first_ev    <= '0;
            first_frame <= '0;
        end else begin
            if (sync) frame_no <= frame_no + 16'd1;
            if (slow_snap) begin
                first_ev    <= first_hit ? cmp_event : sh_ev;
                first_frame <= first_hit ? frame_no : sh_frame;
                sh_ev       <= '0;
                sh_frame    <= '0;
                sh_full     <= 1'b0;
            end else if (first_hit) begin
                sh_ev    <= cmp_event;
                sh_frame <= frame_no;
                sh_full  <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mp_lock_monitor.sv
// tb_mp_lock_monitor: directed scenarios plus randomized traffic checked
// against a rule-level reference model of the lock monitor.
module tb_mp_lock_monitor;

    localparam int UF   = 4;
    localparam int CW   = 16;
    localparam int WD   = 16;
    localparam int MAXC = 65535;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sync = 1'b0;
    logic          slow_snap = 1'b0;
    logic [11:0]   cmp_event = '0;
    logic [1:0]    lock_sel = '0;
    logic [15:0]   lock_count = 16'd3;
    logic [11:0]   ev_snap;
    logic [CW-1:0] clip_frames, lol_cnt;
    logic [1:0]    lock_state;
    logic          locked, sync_err;

    int total = 0;
    int bad = 0;

    int m_sticky, m_evsnap, m_frame, m_seen, m_state, m_good, m_bc;
    int m_cacc, m_lacc, m_cout, m_lout, m_wd, m_serr;

    always #5 clk = ~clk;

    mp_lock_monitor #(.UNLOCK_FRAMES(UF), .CW(CW), .WDOG(WD)) dut (
        .clk(clk), .rst(rst), .sync(sync), .cmp_event(cmp_event),
        .lock_sel(lock_sel), .lock_count(lock_count), .slow_snap(slow_snap),
        .ev_snap(ev_snap), .clip_frames(clip_frames), .lol_cnt(lol_cnt),
        .lock_state(lock_state), .locked(locked), .sync_err(sync_err)
    );

    // Reference: apply the monitor's rules to the inputs seen at one edge
    function automatic void model_edge();
        int closed, need, csum, lsum;
        bit quiet, bad_f, clip, lol;
        if (rst) begin
            m_sticky = 0; m_evsnap = 0; m_frame = 0; m_seen = 0;
            m_state = 0; m_good = 0; m_bc = 0; m_cacc = 0; m_lacc = 0;
            m_cout = 0; m_lout = 0; m_wd = 0; m_serr = 0;
            return;
        end
        closed = m_frame | int'(cmp_event);
        clip = 0;
        lol = 0;
        quiet = !sync && (m_wd + 1 >= WD);
        need = (lock_count == 0) ? 1 : int'(lock_count);
        if (quiet) begin
            if (m_state == 2) lol = 1;
            m_state = 0; m_good = 0; m_bc = 0;
        end else if (sync && m_seen != 0) begin
            clip = (closed & 'hF00) != 0;
            bad_f = clip || (((closed >> (2 * int'(lock_sel))) & 3) != 0);
            if (m_state == 0) begin
                if (!bad_f) begin
                    m_good = 1;
                    m_state = (m_good >= need) ? 2 : 1;
                end
            end else if (m_state == 1) begin
                if (bad_f) begin
                    m_state = 0; m_good = 0;
                end else begin
                    if (m_good < 65535) m_good++;
                    if (m_good >= need) m_state = 2;
                end
            end else begin
                if (bad_f) begin
                    m_bc++;
                    if (m_bc >= UF) begin
                        m_bc = 0; m_state = 0; lol = 1;
                    end
                end else begin
                    m_bc = 0;
                end
            end
        end
        m_wd = sync ? 0 : ((m_wd < WD) ? m_wd + 1 : m_wd);
        if (quiet) m_serr = 1;
        else if (slow_snap) m_serr = 0;
        csum = m_cacc + int'(clip);
        if (csum > MAXC) csum = MAXC;
        lsum = m_lacc + int'(lol);
        if (lsum > MAXC) lsum = MAXC;
        if (slow_snap) begin
            m_cout = csum; m_cacc = 0;
            m_lout = lsum; m_lacc = 0;
            m_evsnap = m_sticky | int'(cmp_event);
            m_sticky = 0;
        end else begin
            m_cacc = csum;
            m_lacc = lsum;
            m_sticky = m_sticky | int'(cmp_event);
        end
        m_frame = sync ? 0 : closed;
        if (sync) m_seen = 1;
    endfunction

    task automatic step(input logic s, input logic [11:0] ev, input logic sn);
        sync = s;
        cmp_event = ev;
        slow_snap = sn;
        @(posedge clk);
        model_edge();
        #1;
        sync = 1'b0;
        cmp_event = '0;
        slow_snap = 1'b0;
    endtask

    task automatic frame(input int len, input logic [11:0] ev, input int at);
        for (int i = 0; i < len; i++) step(i == len - 1, (i == at) ? ev : 12'h000, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lock_count = 16'd3;
        lock_sel = 2'd0;
        step(1'b0, 12'h000, 1'b0);
        step(1'b1, 12'hFFF, 1'b1);
        total++;
        if ({ev_snap, clip_frames, lol_cnt, lock_state, locked, sync_err} !== '0) begin
            bad++;
            $display("FAIL reset: outputs=%h required 0",
                     {ev_snap, clip_frames, lol_cnt, lock_state, locked, sync_err});
        end
        rst = 1'b0;
    endtask

    task automatic test_acquire();
        lock_count = 16'd3;
        lock_sel = 2'd0;
        frame(8, 12'h000, -1);
        total++;
        if (lock_state !== 2'd0) begin
            bad++; $display("FAIL acq_close1: state=%0d required 0", lock_state);
        end
        frame(8, 12'h000, -1);
        total++;
        if (lock_state !== 2'd1) begin
            bad++; $display("FAIL acq_close2: state=%0d required 1", lock_state);
        end
        frame(8, 12'h000, -1);
        total++;
        if (lock_state !== 2'd1 || locked !== 1'b0) begin
            bad++; $display("FAIL acq_close3: state=%0d locked=%b required 1/0", lock_state, locked);
        end
        frame(8, 12'h000, -1);
        total++;
        if (lock_state !== 2'd2 || locked !== 1'b1) begin
            bad++; $display("FAIL acq_close4: state=%0d locked=%b required 2/1", lock_state, locked);
        end
    endtask

    task automatic test_lol();
        lock_sel = 2'd1;
        for (int f = 0; f < 3; f++) frame(8, 12'h002, 3);
        total++;
        if (lock_state !== 2'd2) begin
            bad++; $display("FAIL lol_other_level: state=%0d required 2", lock_state);
        end
        for (int f = 0; f < 3; f++) frame(8, 12'h008, 3);
        total++;
        if (lock_state !== 2'd2) begin
            bad++; $display("FAIL lol_3bad: state=%0d required 2", lock_state);
        end
        frame(8, 12'h008, 3);
        total++;
        if (lock_state !== 2'd0 || locked !== 1'b0) begin
            bad++; $display("FAIL lol_4bad: state=%0d locked=%b required 0/0", lock_state, locked);
        end
        step(1'b0, 12'h000, 1'b1);
        total++;
        if (lol_cnt !== 16'd1 || ev_snap !== 12'h00A || clip_frames !== 16'd0) begin
            bad++;
            $display("FAIL lol_snap: lol=%0d ev=%h clip=%0d required 1/00a/0",
                     lol_cnt, ev_snap, clip_frames);
        end
    endtask

    task automatic test_clip();
        for (int f = 0; f < 4; f++) frame(8, 12'h100, 2);
        for (int i = 0; i < 7; i++) step(1'b0, (i == 2) ? 12'h100 : 12'h000, 1'b0);
        step(1'b1, 12'h000, 1'b1);
        total++;
        if (clip_frames !== 16'd5 || ev_snap !== 12'h100) begin
            bad++; $display("FAIL clip_snap: clip=%0d ev=%h required 5/100", clip_frames, ev_snap);
        end
        step(1'b0, 12'h000, 1'b1);
        total++;
        if (clip_frames !== 16'd0) begin
            bad++; $display("FAIL clip_resnap: clip=%0d required 0", clip_frames);
        end
    endtask

    task automatic test_snap_coincide();
        step(1'b0, 12'h800, 1'b1);
        total++;
        if (ev_snap !== 12'h800) begin
            bad++; $display("FAIL snap_same_cycle: ev=%h required 800", ev_snap);
        end
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b1);
        total++;
        if (ev_snap !== 12'h000) begin
            bad++; $display("FAIL snap_cleared: ev=%h required 000", ev_snap);
        end
    endtask

    task automatic test_watchdog();
        lock_count = 16'd1;
        lock_sel = 2'd0;
        frame(8, 12'h000, -1);
        frame(8, 12'h000, -1);
        total++;
        if (lock_state !== 2'd2) begin
            bad++; $display("FAIL wd_prelock: state=%0d required 2", lock_state);
        end
        step(1'b0, 12'h000, 1'b1);
        step(1'b1, 12'h000, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 12'h000, 1'b0);
            if (i == 15) begin
                total++;
                if (sync_err !== 1'b0 || lock_state !== 2'd2) begin
                    bad++; $display("FAIL wd_early: err=%b state=%0d required 0/2", sync_err, lock_state);
                end
            end
            if (i == 16) begin
                total++;
                if (sync_err !== 1'b1 || lock_state !== 2'd0) begin
                    bad++; $display("FAIL wd_trip: err=%b state=%0d required 1/0", sync_err, lock_state);
                end
            end
        end
        step(1'b1, 12'h000, 1'b0);
        total++;
        if (sync_err !== 1'b1) begin
            bad++; $display("FAIL wd_sticky: err=%b required 1", sync_err);
        end
        step(1'b0, 12'h000, 1'b1);
        total++;
        if (sync_err !== 1'b0 || lol_cnt !== 16'd1) begin
            bad++; $display("FAIL wd_snap: err=%b lol=%0d required 0/1", sync_err, lol_cnt);
        end
    endtask

    task automatic test_reset_mid();
        lock_count = 16'd5;
        lock_sel = 2'd0;
        rst = 1'b1;
        step(1'b0, 12'h000, 1'b0);
        rst = 1'b0;
        frame(8, 12'h000, -1);
        frame(8, 12'h000, -1);
        total++;
        if (lock_state !== 2'd1) begin
            bad++; $display("FAIL rm_acquire: state=%0d required 1", lock_state);
        end
        step(1'b0, 12'h0FF, 1'b1);
        total++;
        if (ev_snap !== 12'h0FF) begin
            bad++; $display("FAIL rm_presnap: ev=%h required 0ff", ev_snap);
        end
        step(1'b0, 12'h003, 1'b0);
        rst = 1'b1;
        step(1'b0, 12'h000, 1'b0);
        rst = 1'b0;
        total++;
        if ({ev_snap, clip_frames, lol_cnt, lock_state, locked, sync_err} !== '0) begin
            bad++;
            $display("FAIL rm_cleared: outputs=%h required 0",
                     {ev_snap, clip_frames, lol_cnt, lock_state, locked, sync_err});
        end
        frame(8, 12'h000, -1);
        total++;
        if (lock_state !== 2'd0) begin
            bad++; $display("FAIL rm_first_sync: state=%0d required 0", lock_state);
        end
        frame(8, 12'h000, -1);
        total++;
        if (lock_state !== 2'd1) begin
            bad++; $display("FAIL rm_second_sync: state=%0d required 1", lock_state);
        end
    endtask

    task automatic test_random();
        int gap, since;
        logic s, sn;
        logic [11:0] ev;
        int lcs[5] = '{0, 1, 2, 3, 5};
        rst = 1'b1;
        step(1'b0, 12'h000, 1'b0);
        rst = 1'b0;
        gap = 8;
        since = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 63) == 0) lock_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) lock_count = 16'(lcs[$urandom_range(0, 4)]);
            rst = ($urandom_range(0, 599) == 0);
            since++;
            s = (since >= gap);
            if (s) begin
                since = 0;
                gap = ($urandom_range(0, 19) == 0) ? 22 : int'($urandom_range(1, 12));
            end
            ev = ($urandom_range(0, 23) == 0) ? 12'(1 << $urandom_range(0, 11)) : 12'h000;
            sn = ($urandom_range(0, 9) == 0);
            step(s, ev, sn);
            rst = 1'b0;
            total++;
            if ({ev_snap, clip_frames, lol_cnt, lock_state, locked, sync_err} !==
                {12'(m_evsnap), 16'(m_cout), 16'(m_lout), 2'(m_state),
                 (m_state == 2), (m_serr != 0)}) begin
                bad++;
                $display("FAIL random c=%0d: ev=%h clip=%0d lol=%0d st=%0d lk=%b err=%b required ev=%h clip=%0d lol=%0d st=%0d err=%0d",
                         c, ev_snap, clip_frames, lol_cnt, lock_state, locked, sync_err,
                         12'(m_evsnap), m_cout, m_lout, m_state, m_serr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_lol();
        test_clip();
        test_snap_coincide();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
